// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive/transmit blocks:
//   - receiver FSM state encoding
//   - parity mode constants
//   - baud divisor helper used by every tick generator
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE      = 3'd0;
  localparam rx_state_t ST_START     = 3'd1;
  localparam rx_state_t ST_DATA      = 3'd2;
  localparam rx_state_t ST_PARITY    = 3'd3;
  localparam rx_state_t ST_STOP      = 3'd4;
  localparam rx_state_t ST_WAIT_HIGH = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per oversample tick; callers must choose parameters giving >= 1.
  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running oversample tick generator: tick pulses for one clk every
// baud_div(CLK_FREQ, BAUD, OVERSAMPLE) clocks. clr restarts the count so the
// next tick lands a full divisor period later (phase alignment to an edge).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous counter clear
//   tick - one-clk oversample strobe
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // With DIV == 1 the counter sits at 0 and tick is asserted every clk.
  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// Oversampling UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2
// stop bits. Frames are delivered with their error flags over valid/ready.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   rx         - asynchronous serial input, idle high
//   data_out   - received word (first bit on the line is the LSB)
//   data_valid - data_out / frame_err / parity_err hold a pending word
//   data_ready - consumer accepts the word when data_valid && data_ready
//   frame_err  - a stop bit of this word was sampled low
//   parity_err - parity mismatch on this word (always 0 without parity)
//   overrun    - sticky: a word was dropped because the previous one was unread
// -----------------------------------------------------------------------------
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int OSW = $clog2(OVERSAMPLE);

  rx_state_t            state_q, state_d;
  logic                 sync1_q, rxs_q;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 commit_q, commit_d;

  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, sample;

  // Holding the tick counter clear while idle phase-aligns all bit timing to
  // the synchronized start edge.
  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_IDLE),
    .tick(tick)
  );

  // Sample point: half a bit into the start bit, then every full bit period,
  // which keeps each later sample at mid-bit.
  assign sample = tick && (os_cnt_q == ((state_q == ST_START) ? OSW'(OVERSAMPLE/2 - 1)
                                                              : OSW'(OVERSAMPLE - 1)));

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    commit_d   = 1'b0;

    if (tick) os_cnt_d = sample ? '0 : os_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        os_cnt_d   = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        if (!rxs_q) begin
          state_d = ST_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: if (sample) state_d = rxs_q ? ST_IDLE : ST_DATA;
      ST_DATA: if (sample) begin
        shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
          bit_cnt_d = '0;
          state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_PARITY: if (sample) begin
        perr_d  = ((^shift_q) ^ rxs_q) != ((PARITY == PARITY_ODD) ? 1'b1 : 1'b0);
        state_d = ST_STOP;
      end
      ST_STOP: if (sample) begin
        if (!rxs_q) ferr_d = 1'b1;
        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
          commit_d = 1'b1;
          // Leaving at mid-stop lets a back-to-back start edge be caught; a
          // low stop must see the line recover first so a break is one word.
          state_d  = (ferr_q || !rxs_q) ? ST_WAIT_HIGH : ST_IDLE;
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      ST_WAIT_HIGH: if (rxs_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output word register and handshake. commit_q lags the last stop sample
  // by one clk so ferr_q already includes that sample.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (commit_q) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shift_q;
        frame_err_d  = ferr_q;
        parity_err_d = perr_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= ST_IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      commit_q     <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= rx;
      rxs_q        <= sync1_q;
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      commit_q     <= commit_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Directed bench for uart_rx_os at DIV=2 (one bit = 32 clk). Three instances:
//   u_a : 8N1        (basic frame, framing/break, false start, overrun)
//   u_b : 7E1        (parity)
//   u_c : 8N2        (reset mid-frame)
// -----------------------------------------------------------------------------
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int CF = 3200000;
  localparam int BR = 100000;
  localparam int OS = 16;
  localparam int BIT_CLK = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic valid_a, valid_b, valid_c;
  logic fe_a, fe_b, fe_c, pe_a, pe_b, pe_c, ovr_a, ovr_b, ovr_c;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_a = 0;
  logic valid_a_prev = 1'b0;

  // Accept-side captures
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  logic [7:0] cap_d_a = '0, cap_d_c = '0;
  logic [6:0] cap_d_b = '0;
  logic cap_fe_a = 0, cap_pe_a = 0, cap_fe_b = 0, cap_pe_b = 0, cap_fe_c = 0, cap_pe_c = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data_out(data_a), .data_valid(valid_a), .data_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a));
  uart_rx_os #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data_out(data_b), .data_valid(valid_b), .data_ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b));
  uart_rx_os #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rx(rx_c), .data_out(data_c), .data_valid(valid_c), .data_ready(ready_c),
    .frame_err(fe_c), .parity_err(pe_c), .overrun(ovr_c));

  // Record every accepted word and the rise time of u_a's data_valid.
  always @(negedge clk) begin
    if (valid_a && !valid_a_prev) rise_a = cyc;
    valid_a_prev = valid_a;
    if (valid_a && ready_a) begin cnt_a++; cap_d_a = data_a; cap_fe_a = fe_a; cap_pe_a = pe_a; end
    if (valid_b && ready_b) begin cnt_b++; cap_d_b = data_b; cap_fe_b = fe_b; cap_pe_b = pe_b; end
    if (valid_c && ready_c) begin cnt_c++; cap_d_c = data_c; cap_fe_c = fe_c; cap_pe_c = pe_c; end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_rx(which, v);
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                            input bit use_par, input logic pbit, input int nstop, input logic stop_v);
    start_cyc = cyc;
    drive_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(which, d[i]);
    if (use_par) drive_bit(which, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(which, stop_v);
    set_rx(which, 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (data_a !== 8'h00) $display("FAIL reset_data: got %h want 00", data_a); else passed++;
    checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_a); else passed++;
    checks++; if ({fe_a, pe_a, ovr_a} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {fe_a, pe_a, ovr_a}); else passed++;
    checks++; if ({valid_b, valid_c} !== 2'b00) $display("FAIL reset_valid_bc: got %b want 00", {valid_b, valid_c}); else passed++;
    rst = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_8n1;
    int c0;
    c0 = cnt_a;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    checks++; if (cnt_a !== c0 + 1) $display("FAIL 8n1_accepts: got %0d want %0d", cnt_a - c0, 1); else passed++;
    checks++; if (cap_d_a !== 8'hA5) $display("FAIL 8n1_data: got %h want a5", cap_d_a); else passed++;
    checks++; if ({cap_fe_a, cap_pe_a} !== 2'b00) $display("FAIL 8n1_flags: got %b want 00", {cap_fe_a, cap_pe_a}); else passed++;
    checks++;
    if ((rise_a - start_cyc) < 304 || (rise_a - start_cyc) > 312)
      $display("FAIL 8n1_latency: got %0d clk want 304..312", rise_a - start_cyc);
    else passed++;
    $display("8n1: data=%h latency=%0d", cap_d_a, rise_a - start_cyc);
    repeat (32) @(negedge clk);
  endtask

  task automatic test_parity;
    send_frame(1, 9'h041, 7, 1, 1'b0, 1, 1'b1);
    checks++; if (cap_d_b !== 7'h41) $display("FAIL par_good_data: got %h want 41", cap_d_b); else passed++;
    checks++; if ({cap_pe_b, cap_fe_b} !== 2'b00) $display("FAIL par_good_flags: got %b want 00", {cap_pe_b, cap_fe_b}); else passed++;
    $display("parity good: data=%h perr=%b", cap_d_b, cap_pe_b);
    repeat (32) @(negedge clk);
    send_frame(1, 9'h041, 7, 1, 1'b1, 1, 1'b1);
    checks++; if (cap_d_b !== 7'h41) $display("FAIL par_bad_data: got %h want 41", cap_d_b); else passed++;
    checks++; if ({cap_pe_b, cap_fe_b} !== 2'b10) $display("FAIL par_bad_flags: got %b want 10", {cap_pe_b, cap_fe_b}); else passed++;
    checks++; if (cnt_b !== 2) $display("FAIL par_count: got %0d want 2", cnt_b); else passed++;
    $display("parity bad: data=%h perr=%b", cap_d_b, cap_pe_b);
    repeat (32) @(negedge clk);
  endtask

  task automatic test_framing_break;
    int c0;
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b0);
    checks++; if (cap_d_a !== 8'h3C) $display("FAIL ferr_data: got %h want 3c", cap_d_a); else passed++;
    checks++; if ({cap_fe_a, cap_pe_a} !== 2'b10) $display("FAIL ferr_flags: got %b want 10", {cap_fe_a, cap_pe_a}); else passed++;
    $display("framing: data=%h ferr=%b", cap_d_a, cap_fe_a);
    repeat (BIT_CLK) @(negedge clk);
    c0 = cnt_a;
    set_rx(0, 1'b0);
    repeat (20 * BIT_CLK) @(negedge clk);
    checks++; if (cnt_a !== c0 + 1) $display("FAIL break_count: got %0d want 1", cnt_a - c0); else passed++;
    checks++; if (cap_d_a !== 8'h00) $display("FAIL break_data: got %h want 00", cap_d_a); else passed++;
    checks++; if (cap_fe_a !== 1'b1) $display("FAIL break_ferr: got %b want 1", cap_fe_a); else passed++;
    set_rx(0, 1'b1);
    repeat (3 * BIT_CLK) @(negedge clk);
    checks++; if (cnt_a !== c0 + 1) $display("FAIL break_release_count: got %0d want 1", cnt_a - c0); else passed++;
    $display("break: words=%0d data=%h ferr=%b", cnt_a - c0, cap_d_a, cap_fe_a);
  endtask

  task automatic test_false_start;
    int c0;
    c0 = cnt_a;
    set_rx(0, 1'b0);
    repeat (4) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (3 * BIT_CLK) @(negedge clk);
    checks++; if (cnt_a !== c0) $display("FAIL glitch_count: got %0d want 0", cnt_a - c0); else passed++;
    checks++; if (u_a.state_q !== ST_IDLE) $display("FAIL glitch_state: got %0d want %0d", u_a.state_q, ST_IDLE); else passed++;
    send_frame(0, 9'h096, 8, 0, 1'b0, 1, 1'b1);
    checks++; if (cap_d_a !== 8'h96 || cnt_a !== c0 + 1) $display("FAIL glitch_next: got %h/%0d want 96/1", cap_d_a, cnt_a - c0); else passed++;
    $display("false start: words after glitch=%0d next=%h", cnt_a - c0, cap_d_a);
    repeat (32) @(negedge clk);
  endtask

  task automatic test_back_to_back_overrun;
    ready_a = 1'b0;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    checks++; if ({valid_a, ovr_a} !== 2'b10) $display("FAIL ovr_first: got %b want 10", {valid_a, ovr_a}); else passed++;
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
    checks++; if (data_a !== 8'h11) $display("FAIL ovr_data: got %h want 11", data_a); else passed++;
    checks++; if ({valid_a, ovr_a} !== 2'b11) $display("FAIL ovr_flags: got %b want 11", {valid_a, ovr_a}); else passed++;
    $display("overrun: data=%h valid=%b overrun=%b", data_a, valid_a, ovr_a);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    checks++; if ({valid_a, ovr_a} !== 2'b00) $display("FAIL ovr_accept: got %b want 00", {valid_a, ovr_a}); else passed++;
    $display("accept: valid=%b overrun=%b", valid_a, ovr_a);
    ready_a = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int c0;
    logic [7:0] d;
    ready_c = 1'b0;
    send_frame(2, 9'h033, 8, 0, 1'b0, 2, 1'b1);
    checks++; if ({valid_c, data_c} !== {1'b1, 8'h33}) $display("FAIL rstmid_pre: got %b/%h want 1/33", valid_c, data_c); else passed++;
    d = 8'h77;
    drive_bit(2, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(2, d[i]);
    set_rx(2, d[3]);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({valid_c, data_c} !== 9'h000) $display("FAIL rstmid_word: got %b/%h want 0/00", valid_c, data_c); else passed++;
    checks++; if ({fe_c, pe_c, ovr_c} !== 3'b000) $display("FAIL rstmid_flags: got %b want 000", {fe_c, pe_c, ovr_c}); else passed++;
    set_rx(2, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    ready_c = 1'b1;
    c0 = cnt_c;
    send_frame(2, 9'h05A, 8, 0, 1'b0, 2, 1'b1);
    checks++; if (cnt_c !== c0 + 1 || cap_d_c !== 8'h5A) $display("FAIL rstmid_next: got %0d/%h want 1/5a", cnt_c - c0, cap_d_c); else passed++;
    checks++; if ({cap_fe_c, cap_pe_c, ovr_c} !== 3'b000) $display("FAIL rstmid_next_flags: got %b want 000", {cap_fe_c, cap_pe_c, ovr_c}); else passed++;
    $display("reset mid-frame: next data=%h ferr=%b", cap_d_c, cap_fe_c);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing_break();
    test_false_start();
    test_back_to_back_overrun();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
